pipe_stage_elastic: RTL
=======================

PIPE_STAGE_ELASTIC -- requirements
Module: pipe_stage_elastic

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits.
REQ-002 SHALL have parameter RESET_VAL, default 0, WIDTH-bit value loaded into the data registers on reset and on flush.
REQ-003 SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-004 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port flush_n, input, 1 bit, synchronous active-low clear.
REQ-007 SHALL have port in_valid, input, 1 bit, upstream data valid.
REQ-008 SHALL have port in_ready, output, 1 bit, stage can accept data.
REQ-009 SHALL have port in_data, input, WIDTH bits, upstream payload.
REQ-010 SHALL have port out_valid, output, 1 bit, downstream data valid.
REQ-011 SHALL have port out_ready, input, 1 bit, downstream accepts data.
REQ-012 SHALL have port out_data, output, WIDTH bits, registered payload.
REQ-013 SHALL have port stall_cnt, output, CNT_W bits, count of cycles with out_valid=1 and out_ready=0.

Function
REQ-014 SHALL accept one input beat on every rising edge where in_valid=1 and in_ready=1, and deliver one output beat on every rising edge where out_valid=1 and out_ready=1.
REQ-015 SHALL deliver beats in order, with no loss and no duplication.
REQ-016 SHALL have a minimum latency of 1 cycle from input handshake to out_valid=1.
REQ-017 SHALL drive out_data only from a register, and SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-018 SHALL use occupancy states EMPTY and ONE (plus TWO when the skid buffer is present); out_valid SHALL equal (state != EMPTY).
REQ-019 SHALL transition EMPTY to ONE on input handshake only.
REQ-020 SHALL transition ONE to EMPTY on output handshake only; on simultaneous input and output handshakes it SHALL stay in ONE with new data loaded.
REQ-021 SHALL, when flush_n=0 at a clock edge, go to EMPTY, load RESET_VAL into all data registers and discard any same-cycle input beat; flush SHALL take priority over all handshakes.
REQ-022 SHALL increment stall_cnt on each edge where out_valid=1 and out_ready=0, saturating at 2^CNT_W-1; flush SHALL NOT clear stall_cnt.

Reset
REQ-023 SHALL, while rst_n=0 (asynchronously), force state to EMPTY, out_valid to 0, out_data and the skid data to RESET_VAL, and stall_cnt to 0.
REQ-024 SHALL drive in_ready=1 from the first edge after rst_n deasserts, and reset asserted mid-transfer SHALL discard all held beats.

Configuration
REQ-025 SHALL, with macro PIPE_SKID_BUFFER_EN defined, add a skid slot and state TWO and drive in_ready = (state != TWO) directly from a register, with no combinational path from out_ready.
REQ-026 SHALL, in skid mode, move ONE to TWO on input handshake without output handshake, move TWO to ONE on output handshake (skid data promoted to out_data on the same edge), and sustain full throughput under continuous flow.
REQ-027 SHALL, without PIPE_SKID_BUFFER_EN, drive in_ready = (out_valid=0) or (out_ready=1) combinationally and never reach TWO.

Structure
REQ-028 SHALL place the state encoding (EMPTY/ONE/TWO) and the default CNT_W constant in shared package pipe_pkg.
REQ-029 SHALL implement each data register as sub-module pipe_data_slot (WIDTH-bit register with load enable, sync clear to RESET_VAL, async reset), instantiated once, or twice with skid.

Verification
REQ-030 SHALL verify: WIDTH=32, in_valid=1 with in_data=0x11,0x22,0x33 on consecutive cycles, out_ready=1 -> out_data=0x11,0x22,0x33 one cycle later, no bubbles.
REQ-031 SHALL verify: skid on, out_ready=0 for 3 cycles while 0xA,0xB are offered -> in_ready=0 after two accepts, stall_cnt=3, and then 0xA,0xB delivered in order.
REQ-032 SHALL verify: state ONE holding 0x55, flush_n=0 with in_valid=1 and in_data=0x66 -> next cycle out_valid=0, out_data=0, and 0x66 never appears.
REQ-033 SHALL verify: rst_n pulsed low asynchronously mid-cycle in state TWO -> out_valid=0 immediately, stall_cnt=0.
REQ-034 SHALL verify: CNT_W=2 with out_ready=0 and out_valid=1 for 6 cycles -> stall_cnt saturates at 3.
REQ-035 SHALL verify: skid off, out_ready toggling 1,0,1 with state ONE -> in_ready follows out_ready in the same cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage: occupancy encoding and
// the default stall-counter width.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  localparam int unsigned CNT_W_DEF = 16;

endpackage

// File: rtl/pipe_data_slot.sv
// One payload register of the elastic stage: load enable, synchronous clear
// to RESET_VAL, asynchronous active-low reset to RESET_VAL.
module pipe_data_slot #(
  parameter int unsigned          WIDTH     = 32,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear wins over load so a flush always lands on RESET_VAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (clr) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Valid/ready register slice with stall counter. Defining PIPE_SKID_BUFFER_EN
// adds a skid slot so in_ready comes from a flop instead of out_ready.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned      CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pipe_state_t      state;
  pipe_state_t      state_nxt;
  logic             valid_q;
  logic [CNT_W-1:0] stall_q;
  logic             flush;
  logic             in_hs;
  logic             out_hs;
  logic             main_load;
  logic [WIDTH-1:0] main_d;

  assign flush     = !flush_n;
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = valid_q && out_ready;
  assign out_valid = valid_q;
  assign stall_cnt = stall_q;

`ifdef PIPE_SKID_BUFFER_EN
  logic             ready_q;
  logic             skid_load;
  logic [WIDTH-1:0] skid_q;

  assign in_ready = ready_q;
  // Draining TWO promotes the skid word into the output register.
  assign main_d   = (state == TWO) ? skid_q : in_data;

  pipe_data_slot #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_skid_slot (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .load  (skid_load),
    .d     (in_data),
    .q     (skid_q)
  );
`else
  assign in_ready = !valid_q || out_ready;
  assign main_d   = in_data;
`endif

  pipe_data_slot #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main_slot (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .load  (main_load),
    .d     (main_d),
    .q     (out_data)
  );

  // Next occupancy and slot load enables; flush overrides every handshake.
  always_comb begin
    state_nxt = state;
    main_load = 1'b0;
`ifdef PIPE_SKID_BUFFER_EN
    skid_load = 1'b0;
`endif
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_hs) begin
            state_nxt = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (in_hs && out_hs) begin
            main_load = 1'b1;
`ifdef PIPE_SKID_BUFFER_EN
          end else if (in_hs) begin
            state_nxt = TWO;
            skid_load = 1'b1;
`endif
          end else if (out_hs) begin
            state_nxt = EMPTY;
          end
        end
`ifdef PIPE_SKID_BUFFER_EN
        TWO: begin
          if (out_hs) begin
            state_nxt = ONE;
            main_load = 1'b1;
          end
        end
`endif
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      valid_q <= 1'b0;
`ifdef PIPE_SKID_BUFFER_EN
      ready_q <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      valid_q <= (state_nxt != EMPTY);
`ifdef PIPE_SKID_BUFFER_EN
      ready_q <= (state_nxt != TWO);
`endif
    end
  end

  // Saturating stall counter; survives flush, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (valid_q && !out_ready && (stall_q != CNT_MAX)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

endmodule
